// File: rtl/fp16_div_seq.sv
// fp16_div_seq -- sequential IEEE-754 half-precision divider.
//
// Restoring radix-2 mantissa division, one quotient bit per cycle, then
// round-to-nearest-even. It uses the same sign, exponent and infinity
// conventions as the companion FP16 multiplier.
//
// Optional feature macro: FP16_DIV_SUBNORM_EN
//   defined   : subnormal operands are normalised and subnormal results are
//               produced with guard/sticky rounding.
//   undefined : subnormal operands count as zero and results with e <= 0
//               flush to signed zero.
//
// Ports
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset
//   start_i    : operation request, sampled only while idle
//   a_i, b_i   : dividend / divisor (FP16), captured on accept
//   quot_o     : registered quotient, holds until the next result
//   overflow_o : infinite/NaN result flag, registered with quot_o
//   busy_o     : high from the cycle after accept through the done cycle
//   done_o     : one-cycle pulse, quot_o/overflow_o valid
`timescale 1ns/1ps
module fp16_div_seq (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic [15:0] quot_o,
   output logic        overflow_o,
   output logic        busy_o,
   output logic        done_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PREP  = 3'd1;
   localparam logic [2:0] S_DIV   = 3'd2;
   localparam logic [2:0] S_ROUND = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

`ifdef FP16_DIV_SUBNORM_EN
   // Left shift that moves the leading one of m to bit 10.
   function automatic logic [3:0] lzc11(input logic [10:0] m);
      lzc11 = 4'd0;
      for (int i = 0; i < 11; i++) begin
         if (m[i]) lzc11 = 4'(10 - i);
      end
   endfunction
`endif

   logic [2:0]        state_q, state_d;
   logic [15:0]       a_q, a_d, b_q, b_d;
   logic              sign_q, sign_d;
   logic signed [6:0] exp_q, exp_d;
   logic [11:0]       rem_q, rem_d;
   logic [10:0]       div_q, div_d;
   logic [12:0]       quo_q, quo_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [15:0]       quot_q, quot_d;
   logic              ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;

   // Operand classification (PREP)
   logic [4:0]        ea_s, eb_s;
   logic [9:0]        fa_s, fb_s;
   logic              sgn_s, a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
   logic [10:0]       ma_s, mb_s;
   logic signed [6:0] eeff_a_s, eeff_b_s;
   // Division step (DIV)
   logic              rem_ge_s;
   logic [10:0]       rem_sub_s;
   // Normalise and round (ROUND)
   logic [10:0]       m_n_s, m_f_s;
   logic              g_s, s_s, rup_s;
   logic signed [6:0] e_n_s, e_f_s;
   logic [11:0]       m_sum_s;
   logic [15:0]       res_s;
   logic              res_ovf_s;
`ifdef FP16_DIV_SUBNORM_EN
   logic [3:0]        lz_a_s, lz_b_s;
   logic signed [6:0] sh_s;
   logic [23:0]       ext_s;
   logic [10:0]       m_sub_s;
   logic              g_sub_s, s_sub_s, rup_sub_s;
`endif

   // Operand classification, mantissa formation and exponent difference
   always_comb begin
      ea_s  = a_q[14:10];
      eb_s  = b_q[14:10];
      fa_s  = a_q[9:0];
      fb_s  = b_q[9:0];
      sgn_s = a_q[15] ^ b_q[15];
      a_nan_s = (ea_s == 5'd31) && (fa_s != 10'd0);
      b_nan_s = (eb_s == 5'd31) && (fb_s != 10'd0);
      a_inf_s = (ea_s == 5'd31) && (fa_s == 10'd0);
      b_inf_s = (eb_s == 5'd31) && (fb_s == 10'd0);
`ifdef FP16_DIV_SUBNORM_EN
      a_zero_s = (ea_s == 5'd0) && (fa_s == 10'd0);
      b_zero_s = (eb_s == 5'd0) && (fb_s == 10'd0);
      lz_a_s   = lzc11({ea_s != 5'd0, fa_s});
      lz_b_s   = lzc11({eb_s != 5'd0, fb_s});
      ma_s     = {ea_s != 5'd0, fa_s} << lz_a_s;
      mb_s     = {eb_s != 5'd0, fb_s} << lz_b_s;
      // Subnormals use an effective exponent of 1 before the shift adjustment.
      eeff_a_s = ((ea_s == 5'd0) ? 7'sd1 : {2'b00, ea_s}) - {3'b000, lz_a_s};
      eeff_b_s = ((eb_s == 5'd0) ? 7'sd1 : {2'b00, eb_s}) - {3'b000, lz_b_s};
`else
      a_zero_s = (ea_s == 5'd0);
      b_zero_s = (eb_s == 5'd0);
      ma_s     = {1'b1, fa_s};
      mb_s     = {1'b1, fb_s};
      eeff_a_s = {2'b00, ea_s};
      eeff_b_s = {2'b00, eb_s};
`endif
   end

   // One restoring-division step; the remainder stays below 2*divisor
   always_comb begin
      rem_ge_s  = rem_q >= {1'b0, div_q};
      if (rem_ge_s) begin
         rem_sub_s = 11'(rem_q - {1'b0, div_q});
      end else begin
         rem_sub_s = rem_q[10:0];
      end
   end

   // Normalise the quotient, round to nearest even, and detect range limits
   always_comb begin
      if (quo_q[12]) begin
         m_n_s = quo_q[12:2];
         g_s   = quo_q[1];
         s_s   = quo_q[0] | (rem_q != 12'd0);
         e_n_s = exp_q;
      end else begin
         m_n_s = quo_q[11:1];
         g_s   = quo_q[0];
         s_s   = (rem_q != 12'd0);
         e_n_s = exp_q - 7'sd1;
      end
      rup_s   = g_s & (s_s | m_n_s[0]);
      m_sum_s = {1'b0, m_n_s} + {11'd0, rup_s};
      if (m_sum_s[11]) begin
         m_f_s = m_sum_s[11:1];
         e_f_s = e_n_s + 7'sd1;
      end else begin
         m_f_s = m_sum_s[10:0];
         e_f_s = e_n_s;
      end
`ifdef FP16_DIV_SUBNORM_EN
      // Denormalise before rounding; bits pushed out collect in sticky.
      sh_s      = 7'sd1 - e_n_s;
      ext_s     = {m_n_s, g_s, 12'd0} >> sh_s[3:0];
      m_sub_s   = ext_s[23:13];
      g_sub_s   = ext_s[12];
      s_sub_s   = s_s | (ext_s[11:0] != 12'd0);
      rup_sub_s = g_sub_s & (s_sub_s | m_sub_s[0]);
      if (e_n_s <= 7'sd0) begin
         res_ovf_s = 1'b0;
         if (sh_s >= 7'sd12) begin
            res_s = {sgn_q_or(sign_q), 15'd0};
         end else begin
            // A carry into bit 10 lands in the exponent field as exp=1.
            res_s = {sign_q, 4'd0, m_sub_s + {10'd0, rup_sub_s}};
         end
      end else if (e_f_s >= 7'sd31) begin
         res_s     = {sign_q, 5'h1F, 10'h000};
         res_ovf_s = 1'b1;
      end else begin
         res_s     = {sign_q, e_f_s[4:0], m_f_s[9:0]};
         res_ovf_s = 1'b0;
      end
`else
      if (e_f_s >= 7'sd31) begin
         res_s     = {sign_q, 5'h1F, 10'h000};
         res_ovf_s = 1'b1;
      end else if (e_f_s <= 7'sd0) begin
         res_s     = {sign_q, 15'd0};
         res_ovf_s = 1'b0;
      end else begin
         res_s     = {sign_q, e_f_s[4:0], m_f_s[9:0]};
         res_ovf_s = 1'b0;
      end
`endif
   end

`ifdef FP16_DIV_SUBNORM_EN
   // Identity helper keeping the zero-result sign expression uniform.
   function automatic logic sgn_q_or(input logic s);
      sgn_q_or = s;
   endfunction
`endif

   // Control FSM and datapath next-state
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sign_d  = sign_q;
      exp_d   = exp_q;
      rem_d   = rem_q;
      div_d   = div_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      ovf_d   = ovf_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               a_d     = a_i;
               b_d     = b_i;
               busy_d  = 1'b1;
               state_d = S_PREP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PREP: begin
            sign_d = sgn_s;
            if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s) || (a_zero_s && b_zero_s)) begin
               quot_d = 16'h7E00;
               ovf_d  = 1'b1;
            end else if (a_inf_s || b_zero_s) begin
               quot_d = {sgn_s, 5'h1F, 10'h000};
               ovf_d  = 1'b1;
            end else begin
               quot_d = {sgn_s, 15'd0};
               ovf_d  = 1'b0;
            end
            if (a_nan_s || b_nan_s || a_inf_s || b_inf_s || a_zero_s || b_zero_s) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               // Normal operand pair: restore the held result and start dividing.
               quot_d  = quot_q;
               ovf_d   = ovf_q;
               rem_d   = {1'b0, ma_s};
               div_d   = mb_s;
               quo_d   = 13'd0;
               cnt_d   = 4'd0;
               exp_d   = eeff_a_s - eeff_b_s + 7'sd15;
               state_d = S_DIV;
            end
         end
         S_DIV: begin
            rem_d = {rem_sub_s, 1'b0};
            quo_d = {quo_q[11:0], rem_ge_s};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd12) begin
               state_d = S_ROUND;
            end else begin
               state_d = S_DIV;
            end
         end
         S_ROUND: begin
            quot_d  = res_s;
            ovf_d   = res_ovf_s;
            done_d  = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         a_q     <= 16'd0;
         b_q     <= 16'd0;
         sign_q  <= 1'b0;
         exp_q   <= 7'sd0;
         rem_q   <= 12'd0;
         div_q   <= 11'd0;
         quo_q   <= 13'd0;
         cnt_q   <= 4'd0;
         quot_q  <= 16'd0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         rem_q   <= rem_d;
         div_q   <= div_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign quot_o     = quot_q;
   assign overflow_o = ovf_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;

endmodule
